// File: rtl/beehive_vr_pkg.sv
// Shared VR replication types: opnum/replica-index widths, the PREPARE_OK header
// and the ack-collector state encoding.
package beehive_vr_pkg;

  localparam int INT_W           = 32;
  localparam int REPLICA_INDEX_W = 8;

  typedef struct packed {
    logic [INT_W-1:0]           view;
    logic [INT_W-1:0]           opnum;
    logic [REPLICA_INDEX_W-1:0] rep_index;
  } prepare_ok_hdr;

  typedef enum logic {
    IDLE      = 1'b0,
    ACK_APPLY = 1'b1
  } ack_state_e;

  // Backups needed besides the primary's own implicit vote.
  function automatic int quorum_threshold(input int num_replicas);
    return (num_replicas - 1) / 2;
  endfunction

endpackage

// File: rtl/prepare_ok_window.sv
// Ack window: head/tail opnum pointers, per-slot replica ack masks and the
// quorum test for the oldest outstanding op.
module prepare_ok_window
  import beehive_vr_pkg::*;
#(
  parameter  int NUM_REPLICAS = 5,
  parameter  int WINDOW_DEPTH = 8,
  localparam int WIN_W        = $clog2(WINDOW_DEPTH),
  localparam int CNT_W        = WIN_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic [INT_W-1:0]           i_flush_opnum,
  input  logic                       i_issue,
  input  logic                       i_commit,
  input  logic                       i_ack_set,
  input  logic [WIN_W-1:0]           i_ack_slot,
  input  logic [REPLICA_INDEX_W-1:0] i_ack_rep,
  output logic [INT_W-1:0]           o_head,
  output logic [INT_W-1:0]           o_tail,
  output logic [CNT_W-1:0]           o_outstanding,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_head_quorum
);

  localparam logic [INT_W-1:0] DEPTH  = INT_W'(WINDOW_DEPTH);
  localparam int               QUORUM = quorum_threshold(NUM_REPLICAS);

  logic [NUM_REPLICAS-1:0] r_mask [WINDOW_DEPTH];
  logic [INT_W-1:0]        r_head;
  logic [INT_W-1:0]        r_tail;
  logic [INT_W-1:0]        w_span;
  logic [WIN_W-1:0]        w_head_slot;
  logic [WIN_W-1:0]        w_tail_slot;
  logic [NUM_REPLICAS-1:0] w_ack_bit;

  assign w_head_slot = r_head[WIN_W-1:0];
  assign w_tail_slot = r_tail[WIN_W-1:0];
  assign w_span      = r_tail - r_head;

  assign o_head        = r_head;
  assign o_tail        = r_tail;
  assign o_outstanding = w_span[CNT_W-1:0];
  assign o_full        = (w_span == DEPTH);
  assign o_empty       = (r_head == r_tail);
  assign o_head_quorum = ($countones(r_mask[w_head_slot]) >= QUORUM);

  // NOTE: give every always_comb output a default first; a path that leaves it unassigned infers a latch.
  always_comb begin
    w_ack_bit = '0;
    for (int r = 0; r < NUM_REPLICAS; r++) begin
      if (i_ack_rep == REPLICA_INDEX_W'(r)) w_ack_bit[r] = 1'b1;
    end
  end

  // Issue clears the tail slot, commit clears the head slot and an ack sets a
  // bit inside [head, tail); the three never address the same slot together.
  // NOTE: sequential state uses <= so each flop samples pre-edge values whatever the statement order.
  // NOTE: the masks are a handful of flops that must read zero straight after reset, so unlike a RAM they take the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= INT_W'(1);
      r_tail <= INT_W'(1);
      for (int s = 0; s < WINDOW_DEPTH; s++) r_mask[s] <= '0;
    end else if (i_flush) begin
      r_head <= i_flush_opnum + INT_W'(1);
      r_tail <= i_flush_opnum + INT_W'(1);
      for (int s = 0; s < WINDOW_DEPTH; s++) r_mask[s] <= '0;
    end else begin
      if (i_issue) begin
        r_mask[w_tail_slot] <= '0;
        r_tail              <= r_tail + INT_W'(1);
      end
      if (i_commit) begin
        r_mask[w_head_slot] <= '0;
        r_head              <= r_head + INT_W'(1);
      end
      if (i_ack_set) r_mask[i_ack_slot] <= r_mask[i_ack_slot] | w_ack_bit;
    end
  end

endmodule

// File: rtl/prepare_ok_collector.sv
// Primary-side PREPARE_OK collector: tracks issued prepares, validates incoming
// acks and emits ops in order once each reaches quorum.
module prepare_ok_collector
  import beehive_vr_pkg::*;
#(
  parameter  int NUM_REPLICAS = 5,
  parameter  int WINDOW_DEPTH = 8,
  localparam int WIN_W        = $clog2(WINDOW_DEPTH),
  localparam int CNT_W        = WIN_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prep_issue_val,
  input  logic [INT_W-1:0]           prep_issue_opnum,
  output logic                       prep_issue_rdy,
  input  logic                       udp_prep_ok_val,
  input  prepare_ok_hdr              udp_prep_ok_hdr,
  output logic                       udp_prep_ok_rdy,
  input  logic [INT_W-1:0]           curr_view,
  input  logic [REPLICA_INDEX_W-1:0] my_replica_index,
  input  logic                       flush,
  input  logic [INT_W-1:0]           flush_opnum,
  output logic                       commit_val,
  output logic [INT_W-1:0]           commit_opnum,
  input  logic                       commit_rdy,
  output logic [15:0]                drop_cnt,
  output logic                       proto_err,
  output logic [CNT_W-1:0]           outstanding
);

  ack_state_e       r_state;
  ack_state_e       w_state_nxt;
  prepare_ok_hdr    r_hdr;
  logic             r_commit_val;
  logic [INT_W-1:0] r_commit_opnum;
  logic [15:0]      r_drop_cnt;
  logic             r_proto_err;

  logic [INT_W-1:0] w_head;
  logic [INT_W-1:0] w_tail;
  logic             w_full;
  logic             w_empty;
  logic             w_head_quorum;
  logic             w_apply;
  logic             w_issue_fire;
  logic             w_commit_fire;
  logic             w_in_window;
  logic             w_rep_ok;
  logic             w_valid;
  logic             w_retiring;
  logic             w_ack_set;
  logic             w_drop;

  prepare_ok_window #(
    .NUM_REPLICAS (NUM_REPLICAS),
    .WINDOW_DEPTH (WINDOW_DEPTH)
  ) u_window (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_flush_opnum (flush_opnum),
    .i_issue       (w_issue_fire),
    .i_commit      (w_commit_fire),
    .i_ack_set     (w_ack_set),
    .i_ack_slot    (r_hdr.opnum[WIN_W-1:0]),
    .i_ack_rep     (r_hdr.rep_index),
    .o_head        (w_head),
    .o_tail        (w_tail),
    .o_outstanding (outstanding),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_head_quorum (w_head_quorum)
  );

  assign prep_issue_rdy = !w_full;
  assign w_issue_fire   = prep_issue_val && !w_full;
  assign w_commit_fire  = r_commit_val && commit_rdy;

  // Ack FSM: accept one header, spend the next cycle applying it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:      if (udp_prep_ok_val) w_state_nxt = ACK_APPLY;
        ACK_APPLY: w_state_nxt = IDLE;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    udp_prep_ok_rdy = (r_state == IDLE);
    w_apply         = (r_state == ACK_APPLY) && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_hdr <= '0;
    else if (udp_prep_ok_val && udp_prep_ok_rdy)    r_hdr <= udp_prep_ok_hdr;
  end

  // Window membership is a modular distance test so it survives opnum wrap.
  assign w_in_window = (r_hdr.opnum - w_head) < (w_tail - w_head);
  assign w_rep_ok    = (r_hdr.rep_index < REPLICA_INDEX_W'(NUM_REPLICAS)) &&
                       (r_hdr.rep_index != my_replica_index);
  assign w_valid     = (r_hdr.view == curr_view) && w_in_window && w_rep_ok;
  assign w_retiring  = w_commit_fire && (r_hdr.opnum == w_head);
  assign w_ack_set   = w_apply && w_valid && !w_retiring;
  assign w_drop      = w_apply && !w_valid;

  // commit_val rises one cycle after the head slot shows quorum and then holds
  // until accepted; the gap after each handshake limits commits to one per two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_val   <= 1'b0;
      r_commit_opnum <= '0;
    end else if (flush || w_commit_fire) begin
      r_commit_val   <= 1'b0;
    end else if (!r_commit_val && w_head_quorum && !w_empty) begin
      r_commit_val   <= 1'b1;
      r_commit_opnum <= w_head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else if (!flush) begin
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_issue_fire && (prep_issue_opnum != w_tail)) r_proto_err <= 1'b1;
    end
  end

  assign commit_val   = r_commit_val;
  assign commit_opnum = r_commit_opnum;
  assign drop_cnt     = r_drop_cnt;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_prepare_ok_collector.sv
// Directed bench for prepare_ok_collector: an opnum-keyed reference model is
// compared every falling edge, with literal checks pinning key scenarios.
module tb_prepare_ok_collector;
  import beehive_vr_pkg::*;

  localparam int N  = 5;
  localparam int WD = 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       prep_issue_val;
  logic [INT_W-1:0]           prep_issue_opnum;
  logic                       prep_issue_rdy;
  logic                       udp_prep_ok_val;
  prepare_ok_hdr              udp_prep_ok_hdr;
  logic                       udp_prep_ok_rdy;
  logic [INT_W-1:0]           curr_view;
  logic [REPLICA_INDEX_W-1:0] my_replica_index;
  logic                       flush;
  logic [INT_W-1:0]           flush_opnum;
  logic                       commit_val;
  logic [INT_W-1:0]           commit_opnum;
  logic                       commit_rdy;
  logic [15:0]                drop_cnt;
  logic                       proto_err;
  logic [3:0]                 outstanding;

  prepare_ok_collector #(.NUM_REPLICAS(N), .WINDOW_DEPTH(WD)) dut (
    .clk              (clk),
    .rst              (rst),
    .prep_issue_val   (prep_issue_val),
    .prep_issue_opnum (prep_issue_opnum),
    .prep_issue_rdy   (prep_issue_rdy),
    .udp_prep_ok_val  (udp_prep_ok_val),
    .udp_prep_ok_hdr  (udp_prep_ok_hdr),
    .udp_prep_ok_rdy  (udp_prep_ok_rdy),
    .curr_view        (curr_view),
    .my_replica_index (my_replica_index),
    .flush            (flush),
    .flush_opnum      (flush_opnum),
    .commit_val       (commit_val),
    .commit_opnum     (commit_opnum),
    .commit_rdy       (commit_rdy),
    .drop_cnt         (drop_cnt),
    .proto_err        (proto_err),
    .outstanding      (outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: acks kept per opnum, ack acceptance modelled as a one-deep pending slot.
  logic [31:0]     m_head, m_tail, m_copn;
  bit              m_cval, m_perr, m_pend;
  logic [15:0]     m_drop;
  prepare_ok_hdr   m_phdr;
  bit [N-1:0]      m_acks [int unsigned];

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] oh, ot, op;
    bit          do_issue, do_commit, quorum, ok;
    bit [N-1:0]  hm, am;
    if (!rst) begin
      m_head = 1; m_tail = 1; m_acks.delete();
      m_cval = 0; m_copn = 0; m_drop = 0; m_perr = 0; m_pend = 0; m_phdr = '0;
    end else begin
      oh        = m_head;
      ot        = m_tail;
      do_issue  = prep_issue_val && ((ot - oh) != 32'(WD));
      do_commit = m_cval && commit_rdy;
      hm        = m_acks.exists(oh) ? m_acks[oh] : '0;
      quorum    = (oh != ot) && ($countones(hm) >= (N - 1) / 2);
      if (flush) begin
        m_acks.delete();
        m_head = flush_opnum + 1;
        m_tail = flush_opnum + 1;
        m_cval = 0;
        m_pend = 0;
      end else begin
        if (m_pend) begin
          op = m_phdr.opnum;
          ok = (m_phdr.view == curr_view) && ((op - oh) < (ot - oh)) &&
               (int'(m_phdr.rep_index) < N) && (m_phdr.rep_index != my_replica_index);
          if (!ok) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end else if (!(do_commit && op == oh)) begin
            am = m_acks.exists(op) ? m_acks[op] : '0;
            am = am | (N'(1) << m_phdr.rep_index);
            m_acks[op] = am;
          end
          m_pend = 0;
        end else if (udp_prep_ok_val) begin
          m_pend = 1;
          m_phdr = udp_prep_ok_hdr;
        end
        if (do_issue) begin
          if (prep_issue_opnum != ot) m_perr = 1;
          if (m_acks.exists(ot)) m_acks.delete(ot);
          m_tail = ot + 1;
        end
        if (do_commit) begin
          if (m_acks.exists(oh)) m_acks.delete(oh);
          m_head = oh + 1;
          m_cval = 0;
        end else if (!m_cval && quorum) begin
          m_cval = 1;
          m_copn = oh;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cmp_commit_val",   32'(commit_val),      32'(m_cval));
      check("cmp_commit_opnum", commit_opnum,         m_copn);
      check("cmp_issue_rdy",    32'(prep_issue_rdy),  32'((m_tail - m_head) != 32'(WD)));
      check("cmp_ack_rdy",      32'(udp_prep_ok_rdy), 32'(!m_pend));
      check("cmp_outstanding",  32'(outstanding),     m_tail - m_head);
      check("cmp_drop_cnt",     32'(drop_cnt),        32'(m_drop));
      check("cmp_proto_err",    32'(proto_err),       32'(m_perr));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    prep_issue_val = 0; prep_issue_opnum = '0; udp_prep_ok_val = 0; udp_prep_ok_hdr = '0;
    flush = 0; flush_opnum = '0; commit_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    cyc(2);
    rst = 1;
    cyc(1);
  endtask

  task automatic issue(input logic [31:0] op);
    prep_issue_val = 1; prep_issue_opnum = op;
    cyc(1);
    prep_issue_val = 0;
  endtask

  task automatic send_ack(input logic [31:0] v, input logic [31:0] op, input logic [7:0] rep);
    int n = 0;
    while (udp_prep_ok_rdy !== 1'b1 && n < 8) begin cyc(1); n++; end
    check("ack_rdy_wait", 32'(udp_prep_ok_rdy), 1);
    udp_prep_ok_val = 1;
    udp_prep_ok_hdr.view = v; udp_prep_ok_hdr.opnum = op; udp_prep_ok_hdr.rep_index = rep;
    cyc(1);
    udp_prep_ok_val = 0;
    cyc(1);
  endtask

  task automatic wait_commit(input int max_cycles);
    int n = 0;
    while (commit_val !== 1'b1 && n < max_cycles) begin cyc(1); n++; end
    check("wait_commit_val", 32'(commit_val), 1);
  endtask

  int got_op[$];
  int got_t[$];

  initial begin
    idle_inputs();
    curr_view = '0; my_replica_index = '0;
    cyc(2);
    rst = 1;
    cyc(1);

    // Reset state
    check("rst_issue_rdy",   32'(prep_issue_rdy), 1);
    check("rst_ack_rdy",     32'(udp_prep_ok_rdy), 1);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_commit_val",  32'(commit_val), 0);
    check("rst_commit_op",   commit_opnum, 0);
    check("rst_drop",        32'(drop_cnt), 0);
    check("rst_model_head",  m_head, 1);

    // Ops 1..3; quorum on op 1 from replicas 1,2
    for (int op = 1; op <= 3; op++) issue(op);
    check("b_outstanding", 32'(outstanding), 3);
    check("b_model_tail",  m_tail, 4);
    send_ack(0, 1, 1);
    check("b_one_ack", 32'(commit_val), 0);
    send_ack(0, 1, 2);
    cyc(1);
    check("b_commit_val",   32'(commit_val), 1);
    check("b_commit_opnum", commit_opnum, 1);

    // Backpressure hold, duplicate, then invalid acks
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("b_hold_val", 32'(commit_val), 1);
      check("b_hold_op",  commit_opnum, 1);
    end
    send_ack(0, 1, 1);
    check("b_dup_drop", 32'(drop_cnt), 0);
    send_ack(1, 2, 1);
    send_ack(0, 9, 1);
    send_ack(0, 2, 0);
    check("b_drop3",    32'(drop_cnt), 3);
    check("b_still_op", commit_opnum, 1);

    // Ack for op 1 applied in the very cycle op 1 commits
    udp_prep_ok_val = 1;
    udp_prep_ok_hdr.view = 0; udp_prep_ok_hdr.opnum = 1; udp_prep_ok_hdr.rep_index = 3;
    cyc(1);
    udp_prep_ok_val = 0; commit_rdy = 1;
    cyc(1);
    commit_rdy = 0;
    check("b_retire_drop", 32'(drop_cnt), 3);
    check("b_after_val",   32'(commit_val), 0);
    check("b_after_out",   32'(outstanding), 2);
    cyc(3);
    check("b_pending", 32'(commit_val), 0);

    // Full window
    do_reset();
    for (int op = 1; op <= 8; op++) issue(op);
    check("c_full_rdy", 32'(prep_issue_rdy), 0);
    check("c_full_out", 32'(outstanding), 8);
    issue(9);
    check("c_blocked_out",  32'(outstanding), 8);
    check("c_blocked_perr", 32'(proto_err), 0);
    send_ack(0, 1, 1);
    send_ack(0, 1, 2);
    wait_commit(4);
    check("c_commit_op", commit_opnum, 1);
    commit_rdy = 1;
    cyc(1);
    commit_rdy = 0;
    check("c_rdy_after", 32'(prep_issue_rdy), 1);
    check("c_out_after", 32'(outstanding), 7);
    issue(9);
    check("c_refill_out",  32'(outstanding), 8);
    check("c_refill_perr", 32'(proto_err), 0);

    // Out-of-order quorum drains in order
    do_reset();
    for (int op = 1; op <= 4; op++) issue(op);
    send_ack(0, 2, 1); send_ack(0, 2, 2);
    send_ack(0, 3, 3); send_ack(0, 3, 4);
    cyc(2);
    check("d_blocked_by_op1", 32'(commit_val), 0);
    commit_rdy = 1;
    send_ack(0, 1, 4);
    send_ack(0, 1, 1);
    for (int i = 0; i < 12; i++) begin
      if (commit_val === 1'b1) begin got_op.push_back(int'(commit_opnum)); got_t.push_back(i); end
      cyc(1);
    end
    commit_rdy = 0;
    check("d_num_commits", got_op.size(), 3);
    for (int i = 0; i < got_op.size() && i < 3; i++) begin
      check("d_commit_order", got_op[i], i + 1);
      check("d_commit_cycle", got_t[i], 1 + 2 * i);
    end
    check("d_out_left", 32'(outstanding), 1);

    // Flush during ACK_APPLY with commit_val high
    do_reset();
    for (int op = 1; op <= 3; op++) issue(op);
    send_ack(0, 1, 1);
    send_ack(0, 1, 2);
    wait_commit(4);
    udp_prep_ok_val = 1;
    udp_prep_ok_hdr.view = 5; udp_prep_ok_hdr.opnum = 2; udp_prep_ok_hdr.rep_index = 1;
    cyc(1);
    udp_prep_ok_val = 0; flush = 1; flush_opnum = 20;
    cyc(1);
    flush = 0;
    check("e_flush_val",  32'(commit_val), 0);
    check("e_flush_out",  32'(outstanding), 0);
    check("e_flush_drop", 32'(drop_cnt), 0);
    check("e_flush_rdy",  32'(udp_prep_ok_rdy), 1);
    check("e_model_head", m_head, 21);
    issue(21);
    check("e_issue21_out",  32'(outstanding), 1);
    check("e_issue21_perr", 32'(proto_err), 0);
    issue(30);
    check("e_bad_issue_perr", 32'(proto_err), 1);
    check("e_bad_issue_out",  32'(outstanding), 2);

    // Asynchronous reset mid-operation
    send_ack(0, 21, 1);
    send_ack(0, 21, 2);
    wait_commit(4);
    send_ack(9, 22, 1);
    check("e_pre_rst_drop", 32'(drop_cnt), 1);
    #2;
    rst = 0;
    #1;
    check("r_commit_val", 32'(commit_val), 0);
    check("r_commit_op",  commit_opnum, 0);
    check("r_drop",       32'(drop_cnt), 0);
    check("r_perr",       32'(proto_err), 0);
    check("r_out",        32'(outstanding), 0);
    check("r_issue_rdy",  32'(prep_issue_rdy), 1);
    check("r_ack_rdy",    32'(udp_prep_ok_rdy), 1);
    idle_inputs();
    cyc(1);
    rst = 1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
